// File: rtl/wave_ctrl.sv
// Front-panel controller: debounced buttons drive waveform config and restart.
// Optional auto-sweep of the waveform select under WAVE_CTRL_AUTO_SWEEP_EN.
module wave_ctrl #(
    parameter int NUM_FUNC  = 4,
    parameter int DEB_CYC   = 1000000,
    parameter int SWEEP_CYC = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_func,
    input  logic       btn_amp,
    input  logic       btn_peri,
    input  logic       btn_freq,
    input  logic       sweep_en,
    output logic [2:0] func_cnt,
    output logic [2:0] amp_cnt,
    output logic [2:0] peri_cnt,
    output logic [2:0] freq_sel,
    output logic [2:0] freq_dy,
    output logic [2:0] peri_posedge
);

    localparam int DW = $clog2(DEB_CYC + 1);

    typedef enum logic {RUN, APPLY} state_t;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    acc_q, acc_d;
    logic [3:0]    press_q, press_d;
    logic [DW-1:0] deb_q [4];
    logic [DW-1:0] deb_d [4];

    state_t     state_q, state_d;
    logic [2:0] func_q, func_d;
    logic [2:0] amp_q, amp_d;
    logic [2:0] peri_q, peri_d;
    logic [2:0] fsel_q, fsel_d;
    logic [2:0] dy_q, dy_d;
    logic       sweep_hit;
    logic       func_press;
    logic       any_press;

    assign btn_raw = {btn_freq, btn_peri, btn_amp, btn_func};

    // A press is the rising edge of the accepted (debounced) level.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]   = '0;
            acc_d[i]   = acc_q[i];
            press_d[i] = 1'b0;
            if (sync2_q[i] != acc_q[i]) begin
                if (deb_q[i] == DW'(DEB_CYC - 1)) begin
                    acc_d[i]   = ~acc_q[i];
                    press_d[i] = ~acc_q[i];
                end else begin
                    deb_d[i] = deb_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) deb_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            press_q <= press_d;
            for (int i = 0; i < 4; i++) deb_q[i] <= deb_d[i];
        end
    end

`ifdef WAVE_CTRL_AUTO_SWEEP_EN
    localparam int SW = $clog2(SWEEP_CYC + 1);

    logic [SW-1:0] sweep_q, sweep_d;

    always_comb begin
        sweep_d   = '0;
        sweep_hit = 1'b0;
        if (sweep_en && !press_q[0]) begin
            if (sweep_q == SW'(SWEEP_CYC - 1)) begin
                sweep_hit = 1'b1;
            end else begin
                sweep_d = sweep_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sweep_q <= '0;
        else        sweep_q <= sweep_d;
    end
`else
    logic unused_sweep;
    assign unused_sweep = sweep_en;
    assign sweep_hit    = 1'b0;
`endif

    assign func_press = press_q[0] | sweep_hit;
    assign any_press  = func_press | (|press_q[3:1]);

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        amp_d   = amp_q;
        peri_d  = peri_q;
        fsel_d  = fsel_q;
        dy_d    = dy_q;
        if (func_press)
            func_d = (func_q == 3'(NUM_FUNC - 1)) ? 3'd0 : func_q + 3'd1;
        if (press_q[1])
            amp_d = (amp_q == 3'd3) ? 3'd0 : amp_q + 3'd1;
        if (press_q[2])
            peri_d = (peri_q == 3'd3) ? 3'd0 : peri_q + 3'd1;
        if (press_q[3])
            fsel_d = fsel_q + 3'd1;
        unique case (state_q)
            RUN: begin
                if (any_press) begin
                    state_d = APPLY;
                    dy_d    = 3'd0;
                end else begin
                    dy_d = (dy_q >= fsel_q) ? 3'd0 : dy_q + 3'd1;
                end
            end
            APPLY: begin
                if (any_press) begin
                    dy_d = 3'd0;
                end else begin
                    state_d = RUN;
                    dy_d    = (fsel_q != 3'd0) ? 3'd1 : 3'd0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            func_q  <= '0;
            amp_q   <= '0;
            peri_q  <= '0;
            fsel_q  <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            amp_q   <= amp_d;
            peri_q  <= peri_d;
            fsel_q  <= fsel_d;
            dy_q    <= dy_d;
        end
    end

    assign func_cnt     = func_q;
    assign amp_cnt      = amp_q;
    assign peri_cnt     = peri_q;
    assign freq_sel     = fsel_q;
    assign freq_dy      = dy_q;
    assign peri_posedge = {2'b00, state_q == APPLY};

endmodule

// File: tb/tb_wave_ctrl.sv
// Directed bench for wave_ctrl with short debounce and sweep periods.
module tb_wave_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_func, btn_amp, btn_peri, btn_freq;
    logic       sweep_en;
    logic [2:0] func_cnt, amp_cnt, peri_cnt, freq_sel, freq_dy, peri_posedge;

    int errs   = 0;
    int checks = 0;
    int pulses;
    int at;
    int found;

    wave_ctrl #(
        .NUM_FUNC (4),
        .DEB_CYC  (4),
        .SWEEP_CYC(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_func    (btn_func),
        .btn_amp     (btn_amp),
        .btn_peri    (btn_peri),
        .btn_freq    (btn_freq),
        .sweep_en    (sweep_en),
        .func_cnt    (func_cnt),
        .amp_cnt     (amp_cnt),
        .peri_cnt    (peri_cnt),
        .freq_sel    (freq_sel),
        .freq_dy     (freq_dy),
        .peri_posedge(peri_posedge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_freq, btn_peri, btn_amp, btn_func} = m;
    endtask

    task automatic count_pulses(input int n, output int p, output int first);
        p = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (peri_posedge == 3'd1) begin
                p++;
                if (first == 0) first = i;
            end
        end
    endtask

    // Hold buttons 10 cycles, release 10 cycles; count restart pulses.
    task automatic press(input logic [3:0] m, output int p, output int first);
        int p2, f2;
        set_btns(m);
        count_pulses(10, p, first);
        set_btns(4'b0000);
        count_pulses(10, p2, f2);
        p = p + p2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_func"}, func_cnt, 0);
        check({tag, "_amp"}, amp_cnt, 0);
        check({tag, "_peri"}, peri_cnt, 0);
        check({tag, "_fsel"}, freq_sel, 0);
        check({tag, "_dy"}, freq_dy, 0);
        check({tag, "_pp"}, peri_posedge, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        sweep_en = 1'b0;
        set_btns(4'b0000);
        #2;
        check_all_zero("rst");
        #10;
        rst_n = 1'b1;
        tick(3);
        check("idle_dy", freq_dy, 0);

        btn_peri = 1'b1;
        tick(3);
        btn_peri = 1'b0;
        count_pulses(12, pulses, at);
        check("glitch_pulses", pulses, 0);
        check("glitch_peri", peri_cnt, 0);

        press(4'b0100, pulses, at);
        check("peri1_pulses", pulses, 1);
        check("peri1_latency", at, 7);
        check("peri1_val", peri_cnt, 1);
        for (int i = 2; i <= 4; i++) begin
            press(4'b0100, pulses, at);
            check("peri_pulses", pulses, 1);
            check("peri_val", peri_cnt, i % 4);
        end

        for (int i = 1; i <= 4; i++) begin
            press(4'b0001, pulses, at);
            check("func_pulses", pulses, 1);
            check("func_val", func_cnt, i % 4);
        end

        press(4'b1000, pulses, at);
        check("fsel1", freq_sel, 1);
        press(4'b1000, pulses, at);
        check("fsel2", freq_sel, 2);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick(1);
            if (freq_dy == 3'd0) found = 1;
        end
        check("dy_find0", found, 1);
        tick(1);
        check("dy_p1", freq_dy, 1);
        tick(1);
        check("dy_p2", freq_dy, 2);
        tick(1);
        check("dy_p0", freq_dy, 0);

        btn_freq = 1'b1;
        tick(6);
        check("fpress_pre_pp", peri_posedge, 0);
        tick(1);
        check("apply_pp", peri_posedge, 1);
        check("apply_fsel", freq_sel, 3);
        check("apply_dy", freq_dy, 0);
        tick(1);
        check("dy_a1", freq_dy, 1);
        check("dy_a1_pp", peri_posedge, 0);
        tick(1);
        check("dy_a2", freq_dy, 2);
        tick(1);
        check("dy_a3", freq_dy, 3);
        tick(1);
        check("dy_a0", freq_dy, 0);
        btn_freq = 1'b0;
        tick(12);

        press(4'b1010, pulses, at);
        check("simul_pulses", pulses, 1);
        check("simul_amp", amp_cnt, 1);
        check("simul_fsel", freq_sel, 4);

        sweep_en = 1'b1;
`ifdef WAVE_CTRL_AUTO_SWEEP_EN
        count_pulses(24, pulses, at);
        check("sweep_pulses", pulses, 3);
        check("sweep_first", at, 8);
        check("sweep_func", func_cnt, 3);
        sweep_en = 1'b0;
        count_pulses(20, pulses, at);
        check("sweep_off_pulses", pulses, 0);
        check("sweep_off_func", func_cnt, 3);
`else
        count_pulses(24, pulses, at);
        check("nosweep_pulses", pulses, 0);
        check("nosweep_func", func_cnt, 0);
        sweep_en = 1'b0;
`endif

        btn_amp = 1'b1;
        tick(7);
        check("rstmid_pre_pp", peri_posedge, 1);
        check("rstmid_pre_amp", amp_cnt, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        btn_amp = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("post_rst_dy", freq_dy, 0);
            check("post_rst_pp", peri_posedge, 0);
        end
        check("post_rst_amp", amp_cnt, 0);
        check("post_rst_fsel", freq_sel, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wave_ctrl.md
Name: wave_ctrl

Overview:
- Front-panel controller for the function generator.
- Turns four raw push-buttons into the configuration and sequencing signals consumed by every waveform generator: `func_cnt`, `amp_cnt`, `peri_cnt`, the `freq_dy` step strobe and the `peri_posedge` phase-restart pulse.
- Sits between the board buttons and the sine/square/triangle/sawtooth generators, and guarantees that every configuration change restarts the generator address at 0.

Parameters:
- NUM_FUNC, 4, number of selectable waveforms; `func_cnt` wraps at NUM_FUNC-1.
- DEB_CYC, 1000000, stable-level cycles required before a button press is accepted.
- SWEEP_CYC, 100000000, cycles per waveform in auto-sweep (used only with the macro).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_func  in  1  raw button, advance waveform
- btn_amp  in  1  raw button, advance attenuation
- btn_peri  in  1  raw button, advance period
- btn_freq  in  1  raw button, advance step divider
- sweep_en  in  1  auto-sweep request (ignored without macro)
- func_cnt  out  3  selected waveform, 0..NUM_FUNC-1
- amp_cnt  out  3  attenuation index 0..3; output scaled by 1/(amp_cnt+1)
- peri_cnt  out  3  period index 0..3; table length 1000-250*peri_cnt
- freq_sel  out  3  step divider 0..7
- freq_dy  out  3  step phase; generators advance only when 0
- peri_posedge  out  3  value 1 for one cycle = restart generator address, else 0

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM in RUN, all debounce counters 0, sync flops 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter counts while the synced level differs from the accepted level; on reaching DEB_CYC-1 the accepted level toggles and the counter clears.
  - Any mismatch-free cycle clears the counter.
  - A rising edge of the accepted level produces a 1-cycle press pulse.
- Press pulse to output latency: 1 clk for the config register, the same clk as `peri_posedge`.
- Index updates on press, all wrapping increments:
  - func: 0..NUM_FUNC-1
  - amp: 0..3
  - peri: 0..3 (3 gives a 250-sample table)
  - freq_sel: 0..7
- Step counter `freq_dy`:
  - Counts 0,1,..,freq_sel, then back to 0, so generators step once every freq_sel+1 cycles.
  - freq_sel=0 keeps `freq_dy` at 0 permanently.
- FSM states:
  - RUN: `freq_dy` counts normally; any press pulse → APPLY.
  - APPLY (exactly 1 cycle): new indices visible, `peri_posedge`=1, `freq_dy` forced to 0. Next state is RUN, unless another press pulse arrives in this cycle, in which case stay in APPLY and apply it too.
  - After APPLY, the first RUN cycle has `freq_dy`=1 if freq_sel>0, else 0.
- Simultaneous presses in one cycle: every pressed index increments; a single APPLY cycle is taken.
- An `amp_cnt`-only change also restarts; uniform behaviour is required.
- Reset mid-APPLY: outputs return to 0 immediately; no residual `peri_posedge`.
- A button held indefinitely gives exactly one press; release requires DEB_CYC stable cycles before the next press can register.
- Glitches shorter than DEB_CYC cycles are never accepted.

Optional Feature:
- Macro: WAVE_CTRL_AUTO_SWEEP_EN.
- With the macro:
  - While `sweep_en`=1, an internal counter reaching SWEEP_CYC-1 acts as a func press (wrap, APPLY, restart) and clears.
  - A manual func press also clears the counter.
  - `sweep_en`=0 holds the counter at 0.
- Without the macro: no sweep counter is synthesized, and `sweep_en` is unused.

Test Plan:
- Reset: rst_n low mid-operation → all outputs 0 within the same cycle; after release, `func_cnt`=`amp_cnt`=`peri_cnt`=`freq_sel`=0 and `freq_dy` stays 0.
- Debounce (DEB_CYC=4): 3-cycle high glitch on btn_peri → no change; 10-cycle press → `peri_cnt` 0→1 exactly once, with `peri_posedge`=1 for one cycle in the same cycle.
- Wrap: 4 presses of btn_peri → `peri_cnt` sequence 1,2,3,0; 4 presses of btn_func with NUM_FUNC=4 → sequence 1,2,3,0; each press gives one `peri_posedge` pulse.
- Divider: freq_sel=2 → `freq_dy` pattern 0,1,2,0,1,2…; press btn_freq → APPLY cycle has `freq_sel`=3 and `freq_dy`=0, then 1,2,3,0.
- Simultaneous: btn_amp and btn_freq accepted in the same cycle → `amp_cnt` and `freq_sel` both +1, exactly one `peri_posedge` pulse.
- Auto-sweep (macro on, SWEEP_CYC=8, `sweep_en`=1): `func_cnt` increments every 8 cycles with a restart pulse; dropping `sweep_en` → `func_cnt` frozen.
